// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives ROM port A with a byte PC, captures the word
// returned one cycle later and hands {pc, instr} downstream through a 2-entry skid FIFO.

module instr_fetch_checker (
    input logic       clk,
    input logic       rst_n,
    input logic       redirect_valid,
    input logic       inflight,
    input logic       deq,
    input logic [1:0] count
);

    // A capture into a full FIFO with no dequeue and no flush would drop an instruction.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight && !deq && !redirect_valid && (count == 2'd2)));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count != 2'd3);

endmodule

module instr_fetch #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP_C  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_r, pc_n_s;
    logic              inflight_r, inflight_n_s;
    logic [ADDR_W-1:0] inflight_pc_r, inflight_pc_n_s;
    logic [1:0]        count_r, count_n_s;
    // e0 is the head entry, e1 the entry behind it; e0 doubles as the output register.
    logic [ADDR_W-1:0] e0_pc_r, e0_pc_n_s, e1_pc_r, e1_pc_n_s;
    logic [DATA_W-1:0] e0_instr_r, e0_instr_n_s, e1_instr_r, e1_instr_n_s;

    logic              deq_s;
    logic              issue_s;
    logic [2:0]        level_s;

    // Handshake and issue decision.
    always_comb begin
        deq_s   = (count_r != 2'd0) && out_ready;
        level_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, deq_s};
        issue_s = !redirect_valid && (level_s <= 3'd1);
    end

    // Next-state for PC, in-flight tracking and the skid FIFO; redirect overrides everything.
    always_comb begin
        pc_n_s          = pc_r;
        inflight_n_s    = 1'b0;
        inflight_pc_n_s = inflight_pc_r;
        count_n_s       = count_r;
        e0_pc_n_s       = e0_pc_r;
        e0_instr_n_s    = e0_instr_r;
        e1_pc_n_s       = e1_pc_r;
        e1_instr_n_s    = e1_instr_r;

        if (redirect_valid) begin
            pc_n_s    = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_n_s = 2'd0;
        end else begin
            if (issue_s) begin
                pc_n_s          = pc_r + PC_STEP_C;
                inflight_n_s    = 1'b1;
                inflight_pc_n_s = pc_r;
            end else begin
                pc_n_s = pc_r;
            end

            case ({inflight_r, deq_s})
                2'b01: begin
                    if (count_r == 2'd2) begin
                        e0_pc_n_s    = e1_pc_r;
                        e0_instr_n_s = e1_instr_r;
                    end else begin
                        e0_pc_n_s    = e0_pc_r;
                        e0_instr_n_s = e0_instr_r;
                    end
                    count_n_s = count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        e0_pc_n_s    = inflight_pc_r;
                        e0_instr_n_s = rom_q;
                        count_n_s    = 2'd1;
                    end else begin
                        e1_pc_n_s    = inflight_pc_r;
                        e1_instr_n_s = rom_q;
                        count_n_s    = 2'd2;
                    end
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        e0_pc_n_s    = e1_pc_r;
                        e0_instr_n_s = e1_instr_r;
                        e1_pc_n_s    = inflight_pc_r;
                        e1_instr_n_s = rom_q;
                    end else begin
                        e0_pc_n_s    = inflight_pc_r;
                        e0_instr_n_s = rom_q;
                    end
                end
                default: begin
                    count_n_s = count_r;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC_C;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            count_r       <= 2'd0;
            e0_pc_r       <= {ADDR_W{1'b0}};
            e0_instr_r    <= {DATA_W{1'b0}};
            e1_pc_r       <= {ADDR_W{1'b0}};
            e1_instr_r    <= {DATA_W{1'b0}};
        end else begin
            pc_r          <= pc_n_s;
            inflight_r    <= inflight_n_s;
            inflight_pc_r <= inflight_pc_n_s;
            count_r       <= count_n_s;
            e0_pc_r       <= e0_pc_n_s;
            e0_instr_r    <= e0_instr_n_s;
            e1_pc_r       <= e1_pc_n_s;
            e1_instr_r    <= e1_instr_n_s;
        end
    end

    assign rom_addr  = pc_r;
    assign out_valid = (count_r != 2'd0);
    assign out_pc    = e0_pc_r;
    assign out_instr = e0_instr_r;

    instr_fetch_checker u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .inflight       (inflight_r),
        .deq            (deq_s),
        .count          (count_r)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural 1-cycle ROM, scoreboard of expected {pc, instr}
// pairs popped on every downstream handshake, plus per-scenario directed checks.

module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    logic [DW-1:0]    mem [64];
    logic [AW+DW-1:0] sb_q [$];
    logic [AW+DW-1:0] sb_exp;
    bit               sb_en = 1'b0;
    int               checks = 0;
    int               errors = 0;
    int               hs_count = 0;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_q          (rom_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= mem[rom_addr[7:2]];

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    end

    function automatic logic [AW+DW-1:0] exp_item(input logic [AW-1:0] pc);
        return {pc, 32'h1000_0000 + {26'd0, pc[7:2]}};
    endfunction

    task automatic push_seq(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(exp_item(p));
            p = p + 8'd4;
        end
    endtask

    // Scoreboard: inputs change just after posedge, so a handshake seen at negedge fires on the next edge.
    always @(negedge clk) begin
        if (sb_en && rst_n && out_valid && out_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc=%h instr=%h, required no more output", out_pc, out_instr);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({out_pc, out_instr} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             out_pc, out_instr, sb_exp[AW+DW-1:DW], sb_exp[DW-1:0]);
                end
            end
        end
    end

    task automatic apply_reset(input logic ready);
        rst_n = 1'b0;
        sb_en = 1'b0;
        sb_q.delete();
        redirect_valid = 1'b0;
        out_ready = ready;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_count = 0;
    endtask

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect_pc = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        sb_q.delete();
        push_seq({pc[7:2], 2'b00}, 80);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 32'h0 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got valid=%b pc=%h instr=%h addr=%h, required 0 0 0 0",
                     out_valid, out_pc, out_instr, rom_addr);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got valid=%b addr=%h, required 0 00", out_valid, rom_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        push_seq(8'h00, 40);
        sb_en = 1'b1;
        hs_count = 0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 8'h04) begin
            errors++;
            $display("FAIL stream_first_issue: got valid=%b addr=%h, required 0 04", out_valid, rom_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL stream_latency: got valid=%b pc=%h instr=%h, required 1 00 10000000",
                     out_valid, out_pc, out_instr);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (hs_count !== 10 || out_pc !== 8'h28 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_rate: got hs=%0d pc=%h valid=%b, required 10 28 1", hs_count, out_pc, out_valid);
        end
    endtask

    task automatic test_stall();
        apply_reset(1'b0);
        push_seq(8'h00, 40);
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got valid=%b pc=%h, required 1 00", i, out_valid, out_pc);
            end
        end
        checks++;
        if (rom_addr !== 8'h08) begin
            errors++;
            $display("FAIL stall_addr: got addr=%h, required 08", rom_addr);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (hs_count !== 4 || out_pc !== 8'h10 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got hs=%0d pc=%h valid=%b, required 4 10 1", hs_count, out_pc, out_valid);
        end
    endtask

    task automatic test_redirect();
        bit found;
        apply_reset(1'b1);
        push_seq(8'h00, 80);
        sb_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_pc == 8'h10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_reach: got pc=%h after 20 cycles, required 10", out_pc);
        end
        do_redirect(8'h40);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble: got valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 32'h1000_0010) begin
            errors++;
            $display("FAIL redirect_target: got valid=%b pc=%h instr=%h, required 1 40 10000010",
                     out_valid, out_pc, out_instr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_pc !== 8'h44) begin
            errors++;
            $display("FAIL redirect_next: got pc=%h, required 44", out_pc);
        end
    endtask

    task automatic test_misaligned();
        do_redirect(8'h23);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h20) begin
            errors++;
            $display("FAIL misaligned: got valid=%b pc=%h, required 1 20", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_pc;
        do_redirect(8'hF8);
        @(posedge clk);
        exp_pc = 8'hF8;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                errors++;
                $display("FAIL wrap: step %0d got valid=%b pc=%h, required 1 %h", i, out_valid, out_pc, exp_pc);
            end
            exp_pc = exp_pc + 8'd4;
        end
    endtask

    task automatic test_back_to_back();
        redirect_pc = 8'h80;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1;
        redirect_pc = 8'h30;
        do_redirect(8'h30);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h30) begin
            errors++;
            $display("FAIL back_to_back: got valid=%b pc=%h, required 1 30", out_valid, out_pc);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 || rom_addr !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid=%b pc=%h addr=%h, required 0 00 00", out_valid, out_pc, rom_addr);
        end
        sb_en = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_seq(8'h00, 700);
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00) begin
            errors++;
            $display("FAIL async_restart: got valid=%b pc=%h, required 1 00", out_valid, out_pc);
        end
    endtask

    task automatic test_random_ready();
        hs_count = 0;
        for (int i = 0; i < 500; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        checks++;
        if (hs_count < 100) begin
            errors++;
            $display("FAIL random_throughput: got %0d handshakes, required at least 100", hs_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random_ready();
        sb_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
